// File: rtl/cmp_pipe_unit.sv
// Single-stage compare unit with valid/ready handshake, saturating predicate
// counter and running min/max statistics on operand A.
module cmp_pipe_unit #(
   parameter int WIDTH       = 16,
   parameter int CNT_W       = 8,
   parameter bit SIGNED_MODE = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_FUN,
   input  logic             CLR_STATS,
   input  logic             OUT_READY,
   output logic             OUT_VALID,
   output logic [1:0]       CMP_OUT,
   output logic             CMP_Flag,
   output logic [CNT_W-1:0] MATCH_CNT,
   output logic [WIDTH-1:0] MAX_VAL,
   output logic [WIDTH-1:0] MIN_VAL,
   output logic             STATS_VALID
);

   localparam logic [2:0] FUN_NOP = 3'b000;
   localparam logic [2:0] FUN_EQ  = 3'b001;
   localparam logic [2:0] FUN_GT  = 3'b010;
   localparam logic [2:0] FUN_LT  = 3'b011;
   localparam logic [2:0] FUN_NE  = 3'b100;
   localparam logic [2:0] FUN_GE  = 3'b101;
   localparam logic [2:0] FUN_LE  = 3'b110;
   localparam logic [2:0] FUN_TRI = 3'b111;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic lt_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      if (SIGNED_MODE) begin
         return $signed(x) < $signed(y);
      end else begin
         return x < y;
      end
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [1:0]       cmp_q, cmp_d;
   logic             flag_q, flag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic             sv_q, sv_d;

   logic       xfer_in, xfer_out;
   logic       a_eq_b, a_gt_b, a_lt_b;
   logic [1:0] code;
   logic       pred_hit;

   assign IN_READY = !out_valid_q || OUT_READY;
   assign xfer_in  = IN_VALID && IN_READY;
   assign xfer_out = out_valid_q && OUT_READY;

   always_comb begin
      a_eq_b = (A == B);
      a_lt_b = lt_f(A, B);
      a_gt_b = lt_f(B, A);
      code   = 2'b00;
      case (ALU_FUN)
         FUN_EQ:  if (a_eq_b)           code = 2'b01;
         FUN_GT:  if (a_gt_b)           code = 2'b10;
         FUN_LT:  if (a_lt_b)           code = 2'b11;
         FUN_NE:  if (!a_eq_b)          code = 2'b01;
         FUN_GE:  if (a_gt_b || a_eq_b) code = 2'b10;
         FUN_LE:  if (a_lt_b || a_eq_b) code = 2'b11;
         FUN_TRI: begin
            if (a_eq_b)      code = 2'b01;
            else if (a_gt_b) code = 2'b10;
            else             code = 2'b11;
         end
         default: code = 2'b00;
      endcase
      // TRI always yields a nonzero code, so it is not a predicate
      pred_hit = (ALU_FUN != FUN_NOP) && (ALU_FUN != FUN_TRI) && (code != 2'b00);
   end

   always_comb begin
      out_valid_d = out_valid_q;
      cmp_d       = cmp_q;
      flag_d      = flag_q;
      if (xfer_in) begin
         out_valid_d = 1'b1;
         cmp_d       = code;
         flag_d      = 1'b1;
      end else if (xfer_out) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      min_d = min_q;
      sv_d  = sv_q;
      if (CLR_STATS) begin
         cnt_d = '0;
         max_d = '0;
         min_d = '0;
         sv_d  = 1'b0;
      end else if (xfer_in) begin
         if (pred_hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (ALU_FUN != FUN_NOP) begin
            if (!sv_q) begin
               max_d = A;
               min_d = A;
               sv_d  = 1'b1;
            end else begin
               if (lt_f(max_q, A)) max_d = A;
               if (lt_f(A, min_q)) min_d = A;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         cmp_q       <= 2'b00;
         flag_q      <= 1'b0;
         cnt_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         sv_q        <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         cmp_q       <= cmp_d;
         flag_q      <= flag_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         min_q       <= min_d;
         sv_q        <= sv_d;
      end
   end

   assign OUT_VALID   = out_valid_q;
   assign CMP_OUT     = cmp_q;
   assign CMP_Flag    = flag_q;
   assign MATCH_CNT   = cnt_q;
   assign MAX_VAL     = max_q;
   assign MIN_VAL     = min_q;
   assign STATS_VALID = sv_q;

endmodule
